// File: rtl/camera_capture_ctrl_if.sv
// Camera port and marked pixel stream of camera_capture_ctrl.
// master drives the camera side and observes pixels; slave is the capture controller.
interface camera_capture_ctrl_if;
    logic       cam_vsync;
    logic       cam_href;
    logic [9:0] cam_data;
    logic       pix_valid;
    logic [9:0] pix_data;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_eof;

    modport master (
        output cam_vsync, cam_href, cam_data,
        input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data,
        output pix_valid, pix_data, pix_sof, pix_eol, pix_eof
    );
endinterface

// File: rtl/camera_capture_ctrl.sv
// Capture sequencer: arms on request, locks to the next frame boundary and gates one frame
// (or a continuous stream) of camera pixels with geometry checks. Watchdog: CAPTURE_TIMEOUT_EN.
module camera_capture_ctrl #(
    parameter int unsigned LINE_LEN     = 12,
    parameter int unsigned NUM_LINES    = 12,
    parameter int unsigned TIMEOUT_CLKS = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    camera_capture_ctrl_if.slave cam,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    output logic                 busy,
    output logic                 frame_done,
    output logic [1:0]           err_code,
    output logic [15:0]          frame_count
);
    localparam int unsigned ColW  = $clog2(LINE_LEN + 1);
    localparam int unsigned LineW = $clog2(NUM_LINES + 1);
    localparam logic [ColW-1:0]  ColLast  = ColW'(LINE_LEN - 1);
    localparam logic [ColW-1:0]  ColFull  = ColW'(LINE_LEN);
    localparam logic [LineW-1:0] LineLast = LineW'(NUM_LINES - 1);
    localparam logic [1:0]       ErrLen   = 2'd1;
    localparam logic [1:0]       ErrCount = 2'd2;

    typedef enum logic [1:0] {StIdle, StArm, StSync, StActive} state_e;

    state_e           state_q, state_d;
    logic             cont_q, cont_d;
    logic             vsync_s, href_s, vsync_r, href_r;
    logic [9:0]       data_s;
    logic [ColW-1:0]  col_q, col_d;
    logic [LineW-1:0] line_q, line_d;
    logic             pix_valid_q, pix_valid_d;
    logic [9:0]       pix_data_q, pix_data_d;
    logic             sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic             frame_done_q, frame_done_d;
    logic [1:0]       err_q, err_d;
    logic [15:0]      count_q, count_d;

    logic vsync_rise, vsync_fall, href_fall;
    logic pix_here, eol_here, eof_here, len_err;

    assign vsync_rise = vsync_s & ~vsync_r;
    assign vsync_fall = ~vsync_s & vsync_r;
    assign href_fall  = ~href_s & href_r;

    // col_q == ColFull marks a completed line still waiting for href to drop
    assign pix_here = href_s && (col_q != ColFull);
    assign eol_here = pix_here && (col_q == ColLast);
    assign eof_here = eol_here && (line_q == LineLast);
    assign len_err  = (href_s && (col_q == ColFull)) || (href_fall && (col_q != ColFull));

`ifdef CAPTURE_TIMEOUT_EN
    localparam logic [1:0]  ErrTimeout = 2'd3;
    localparam logic [15:0] WdLast     = 16'(TIMEOUT_CLKS - 1);
    logic [15:0] wd_q, wd_d;
    logic        cam_edge;
    assign cam_edge = (vsync_s ^ vsync_r) | (href_s ^ href_r);
`endif

    always_comb begin
        state_d      = state_q;
        cont_d       = cont_q;
        col_d        = col_q;
        line_d       = line_q;
        pix_valid_d  = 1'b0;
        pix_data_d   = pix_data_q;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        eof_d        = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        count_d      = count_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StArm;
                    cont_d  = continuous;
                    err_d   = 2'd0;
                end
            end
            StArm: begin
                if (vsync_rise) state_d = StSync;
            end
            StSync: begin
                if (vsync_fall) begin
                    state_d = StActive;
                    col_d   = '0;
                    line_d  = '0;
                end
            end
            StActive: begin
                if (eof_q) begin
                    // eof pixel went out last cycle; close the frame now
                    frame_done_d = 1'b1;
                    count_d      = count_q + 16'd1;
                    if (!cont_q)        state_d = StIdle;
                    else if (vsync_rise) state_d = StSync;
                    else                 state_d = StArm;
                end else if (vsync_rise && !eof_here) begin
                    err_d   = ErrCount;
                    state_d = StIdle;
                end else if (len_err) begin
                    err_d   = ErrLen;
                    state_d = StIdle;
                end else if (pix_here) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = data_s;
                    sof_d       = (col_q == '0) && (line_q == '0);
                    eol_d       = eol_here;
                    eof_d       = eof_here;
                    col_d       = col_q + 1'b1;
                end else if (href_fall) begin
                    col_d  = '0;
                    line_d = line_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef CAPTURE_TIMEOUT_EN
        wd_d = wd_q + 16'd1;
        if (state_q == StIdle || state_d != state_q || cam_edge) begin
            wd_d = '0;
        end else if (wd_q == WdLast) begin
            wd_d         = '0;
            err_d        = ErrTimeout;
            state_d      = StIdle;
            pix_valid_d  = 1'b0;
            sof_d        = 1'b0;
            eol_d        = 1'b0;
            eof_d        = 1'b0;
        end
`endif

        if (abort) begin
            state_d      = StIdle;
            pix_valid_d  = 1'b0;
            pix_data_d   = pix_data_q;
            sof_d        = 1'b0;
            eol_d        = 1'b0;
            eof_d        = 1'b0;
            frame_done_d = 1'b0;
            err_d        = err_q;
            count_d      = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cont_q       <= 1'b0;
            vsync_s      <= 1'b0;
            href_s       <= 1'b0;
            data_s       <= '0;
            vsync_r      <= 1'b0;
            href_r       <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
            count_q      <= '0;
`ifdef CAPTURE_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            vsync_s      <= cam.cam_vsync;
            href_s       <= cam.cam_href;
            data_s       <= cam.cam_data;
            vsync_r      <= vsync_s;
            href_r       <= href_s;
            col_q        <= col_d;
            line_q       <= line_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            count_q      <= count_d;
`ifdef CAPTURE_TIMEOUT_EN
            wd_q         <= wd_d;
`endif
        end
    end

    assign busy          = (state_q != StIdle);
    assign frame_done    = frame_done_q;
    assign err_code      = err_q;
    assign frame_count   = count_q;
    assign cam.pix_valid = pix_valid_q;
    assign cam.pix_data  = pix_data_q;
    assign cam.pix_sof   = sof_q;
    assign cam.pix_eol   = eol_q;
    assign cam.pix_eof   = eof_q;
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed bench for camera_capture_ctrl on a 12x12 mock camera; pixel stream is scored
// against a position model (data = line index, sof/eol/eof at fixed positions).
module tb_camera_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, continuous, abort;
    logic        busy, frame_done;
    logic [1:0]  err_code;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    camera_capture_ctrl_if bus ();

    camera_capture_ctrl #(
        .LINE_LEN     (12),
        .NUM_LINES    (12),
        .TIMEOUT_CLKS (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cam         (bus),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_code    (err_code),
        .frame_count (frame_count)
    );

    int n_valid = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0, n_bad = 0;
    int b_valid = 0, b_sof = 0, b_eol = 0, b_eof = 0, b_done = 0, b_bad = 0;
    int pos;

    always @(negedge clk) begin
        if (bus.pix_valid) begin
            pos = (n_valid - b_valid) % 144;
            if (bus.pix_data !== 10'(pos / 12) || bus.pix_sof !== (pos == 0) ||
                bus.pix_eol !== (pos % 12 == 11) || bus.pix_eof !== (pos == 143))
                n_bad++;
            n_valid++;
            if (bus.pix_sof) n_sof++;
            if (bus.pix_eol) n_eol++;
            if (bus.pix_eof) n_eof++;
        end else if (bus.pix_sof || bus.pix_eol || bus.pix_eof) begin
            n_bad++;
        end
        if (frame_done) n_done++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_valid = n_valid; b_sof = n_sof; b_eol = n_eol;
        b_eof = n_eof; b_done = n_done; b_bad = n_bad;
    endtask

    task automatic pulse_start(input logic cont);
        @(negedge clk);
        start = 1'b1; continuous = cont;
        @(negedge clk);
        start = 1'b0; continuous = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge clk) bus.cam_vsync = 1'b1;
        tick(3);
        bus.cam_vsync = 1'b0;
        tick(3);
    endtask

    task automatic cam_line(input int idx, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = 10'(idx);
        end
        @(negedge clk) bus.cam_href = 1'b0;
        tick(3);
    endtask

    task automatic cam_frame(input int nlines);
        vsync_pulse();
        for (int l = 0; l < nlines; l++) cam_line(l, 12);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        bus.cam_vsync = 1'b0; bus.cam_href = 1'b0; bus.cam_data = '0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_count", frame_count, 0);
        check("rst_err", err_code, 0);
        check("rst_valid", bus.pix_valid, 0);
        rst_n = 1'b1;
        tick(2);

        // single frame
        snap();
        pulse_start(1'b0);
        check("single_busy_armed", busy, 1);
        cam_frame(12);
        tick(4);
        check("single_pixels", n_valid - b_valid, 144);
        check("single_sof", n_sof - b_sof, 1);
        check("single_eol", n_eol - b_eol, 12);
        check("single_eof", n_eof - b_eof, 1);
        check("single_done", n_done - b_done, 1);
        check("single_stream", n_bad - b_bad, 0);
        check("single_count", frame_count, 1);
        check("single_busy_after", busy, 0);
        check("single_err", err_code, 0);

        // continuous, three frames then abort mid-line of a fourth
        snap();
        pulse_start(1'b1);
        cam_frame(12);
        cam_frame(12);
        cam_frame(12);
        tick(2);
        check("cont_count", frame_count, 4);
        check("cont_done", n_done - b_done, 3);
        check("cont_busy_rearmed", busy, 1);
        vsync_pulse();
        cam_line(0, 12);
        cam_line(1, 12);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cam_href = 1'b1;
            bus.cam_data = 10'd2;
        end
        @(negedge clk);
        check("cont_valid_before_abort", bus.pix_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.cam_href = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", bus.pix_valid, 0);
        check("abort_err", err_code, 0);
        tick(4);
        check("abort_count", frame_count, 4);
        check("abort_eof", n_eof - b_eof, 3);
        check("abort_done", n_done - b_done, 3);
        check("cont_stream", n_bad - b_bad, 0);

        // 11-pixel line on line 5
        snap();
        pulse_start(1'b0);
        vsync_pulse();
        for (int l = 0; l < 5; l++) cam_line(l, 12);
        cam_line(5, 11);
        tick(3);
        check("short_err", err_code, 1);
        check("short_busy", busy, 0);
        check("short_pixels", n_valid - b_valid, 71);
        check("short_done", n_done - b_done, 0);
        check("short_eof", n_eof - b_eof, 0);
        check("short_count", frame_count, 4);
        check("short_stream", n_bad - b_bad, 0);

        // vsync after 10 lines
        snap();
        pulse_start(1'b0);
        check("restart_clears_err1", err_code, 0);
        vsync_pulse();
        for (int l = 0; l < 10; l++) cam_line(l, 12);
        vsync_pulse();
        check("count_err", err_code, 2);
        check("count_busy", busy, 0);
        check("count_pixels", n_valid - b_valid, 120);
        check("count_done", n_done - b_done, 0);
        check("count_eof", n_eof - b_eof, 0);
        check("count_count", frame_count, 4);
        pulse_start(1'b0);
        check("restart_clears_err2", err_code, 0);
        check("restart_busy", busy, 1);
        pulse_abort();
        check("abort_idle", busy, 0);

        // camera held idle after start
        pulse_start(1'b0);
        tick(99);
        check("idle_busy_99", busy, 1);
        check("idle_err_99", err_code, 0);
        tick(1);
`ifdef CAPTURE_TIMEOUT_EN
        check("timeout_err", err_code, 3);
        check("timeout_busy", busy, 0);
`else
        check("no_wd_busy_100", busy, 1);
        tick(200);
        check("no_wd_busy_300", busy, 1);
        check("no_wd_err", err_code, 0);
        pulse_abort();
`endif

        // asynchronous reset mid-line
        pulse_start(1'b0);
        vsync_pulse();
        for (int l = 0; l < 3; l++) cam_line(l, 12);
        @(negedge clk);
        bus.cam_href = 1'b1;
        bus.cam_data = 10'd3;
        tick(3);
        check("pre_rst_valid", bus.pix_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", bus.pix_valid, 0);
        check("arst_data", bus.pix_data, 0);
        check("arst_flags", {bus.pix_sof, bus.pix_eol, bus.pix_eof, frame_done}, 0);
        check("arst_err", err_code, 0);
        check("arst_count", frame_count, 0);
        bus.cam_href = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick(2);
        snap();
        pulse_start(1'b0);
        cam_frame(12);
        tick(4);
        check("post_rst_pixels", n_valid - b_valid, 144);
        check("post_rst_eof", n_eof - b_eof, 1);
        check("post_rst_done", n_done - b_done, 1);
        check("post_rst_stream", n_bad - b_bad, 0);
        check("post_rst_count", frame_count, 1);
        check("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
